isqrt_seq: RTL

Sequential integer square-root responder. It serves the enable/valid handshake issued by the beamforming delay calculator. It takes a 32-bit sum of squares (dx²+dz²) and returns its 16-bit root, one root bit per cycle, using the digit-by-digit restoring algorithm. It sits under the delay calculator in the beamforming path, and the root becomes the per-element focusing delay.

---
 rtl/isqrt_seq.sv | 100 ++++++++++
 1 files changed

// File: rtl/isqrt_seq.sv
// Sequential integer square root: digit-by-digit restoring algorithm, one root bit per cycle.
// Serves an enable/valid handshake; optional round-to-nearest with saturation.
`timescale 1ns/1ps
module isqrt_seq #(
    parameter int unsigned DOUT_W = 16,
    parameter int unsigned ROUND  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [2*DOUT_W-1:0]   din,
    output logic [DOUT_W-1:0]     dout,
    output logic                  valid,
    output logic                  busy,
    output logic [3:0]            cstate
);

    localparam int unsigned DIN_W = 2 * DOUT_W;
    localparam int unsigned REM_W = DOUT_W + 2;
    localparam int unsigned CNT_W = $clog2(DOUT_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RND  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [DIN_W-1:0]   rad;
    logic [DOUT_W-1:0]  root;
    logic [REM_W-1:0]   rem;
    logic [CNT_W-1:0]   cnt;

    logic [REM_W-1:0]   rem_sh;
    logic [REM_W-1:0]   trial;
    logic               take;
    logic               round_up;

    // One restoring step; rem's upper bits are provably zero before the shift.
    always_comb begin
        rem_sh   = REM_W'({rem, rad[DIN_W-1 -: 2]});
        trial    = {root, 2'b01};
        take     = (rem_sh >= trial);
        round_up = (ROUND != 0) && (rem > REM_W'(root)) && !(&root);
    end

    assign cstate = 4'(state);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            dout  <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            rad   <= '0;
            root  <= '0;
            rem   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        rad   <= din;
                        root  <= '0;
                        rem   <= '0;
                        cnt   <= CNT_W'(DOUT_W - 1);
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    rad  <= rad << 2;
                    rem  <= take ? (rem_sh - trial) : rem_sh;
                    root <= DOUT_W'({root, take});
                    if (cnt == '0) begin
                        state <= RND;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RND: begin
                    dout  <= round_up ? (root + DOUT_W'(1)) : root;
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                DONE: begin
                    // Hold the result until the initiator releases enable.
                    if (!enable) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
